// File: rtl/slc3_pkg.sv
// Shared LC-3 datapath types and sizes used by the register-access controller.
package slc3_pkg;

   localparam int NUM_REGS   = 8;
   localparam int REG_IDX_W  = 3;
   localparam int DATA_W     = 16;
   localparam int STARVE_MAX = 3;

   typedef enum logic [1:0] {
      INIT = 2'd0,
      RUN  = 2'd1,
      ACK  = 2'd2
   } state_e;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;
   typedef logic [DATA_W-1:0]    data_t;
   typedef logic [1:0]           starve_t;

endpackage

// File: rtl/reg_access_ctrl_if.sv
// CPU, debug-port and register-file signals seen by the register-access controller.
interface reg_access_ctrl_if;
   import slc3_pkg::*;

   logic     cpu_ld;
   reg_idx_t cpu_dr;
   data_t    cpu_d;
   reg_idx_t cpu_sr1;
   reg_idx_t cpu_sr2;
   logic     cpu_stall;

   logic     dbg_req;
   logic     dbg_we;
   reg_idx_t dbg_addr;
   data_t    dbg_wdata;
   logic     dbg_ack;
   data_t    dbg_rdata;

   logic     rf_ld;
   reg_idx_t rf_dr;
   data_t    rf_d;
   reg_idx_t rf_sr1;
   reg_idx_t rf_sr2;
   data_t    rf_sr1_out;

   modport slave (
      input  cpu_ld, cpu_dr, cpu_d, cpu_sr1, cpu_sr2,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
      input  rf_sr1_out,
      output cpu_stall, dbg_ack, dbg_rdata,
      output rf_ld, rf_dr, rf_d, rf_sr1, rf_sr2
   );

   modport master (
      output cpu_ld, cpu_dr, cpu_d, cpu_sr1, cpu_sr2,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata,
      output rf_sr1_out,
      input  cpu_stall, dbg_ack, dbg_rdata,
      input  rf_ld, rf_dr, rf_d, rf_sr1, rf_sr2
   );

endinterface

// File: rtl/reg_access_ctrl.sv
// Arbitrates register-file access between the CPU writeback path and a debug port,
// and zeroes R0..R7 after reset before letting the CPU run.
module reg_access_ctrl
   import slc3_pkg::*;
(
   input  logic               Clk,
   input  logic               Reset,
   reg_access_ctrl_if.slave   bus
);

   state_e   state_q, state_d;
   reg_idx_t init_cnt_q, init_cnt_d;
   starve_t  starve_cnt_q, starve_cnt_d;
   logic     dbg_ack_q, dbg_ack_d;
   data_t    dbg_rdata_q, dbg_rdata_d;
   logic     grant;

   // Debug wins when the CPU is idle or after it has been passed over STARVE_MAX times.
   assign grant = (state_q == RUN) && bus.dbg_req &&
                  (!bus.cpu_ld || (starve_cnt_q == starve_t'(STARVE_MAX)));

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q      <= INIT;
         init_cnt_q   <= '0;
         starve_cnt_q <= '0;
         dbg_ack_q    <= 1'b0;
         dbg_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         init_cnt_q   <= init_cnt_d;
         starve_cnt_q <= starve_cnt_d;
         dbg_ack_q    <= dbg_ack_d;
         dbg_rdata_q  <= dbg_rdata_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      init_cnt_d   = init_cnt_q;
      starve_cnt_d = starve_cnt_q;
      dbg_ack_d    = grant;
      dbg_rdata_d  = dbg_rdata_q;
      case (state_q)
         INIT: begin
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == reg_idx_t'(NUM_REGS - 1)) state_d = RUN;
         end
         RUN: begin
            if (grant) begin
               state_d      = ACK;
               starve_cnt_d = '0;
               // Sampled before the edge, so a write grant returns the old contents.
               dbg_rdata_d  = bus.rf_sr1_out;
            end else if (bus.dbg_req && bus.cpu_ld &&
                         (starve_cnt_q != starve_t'(STARVE_MAX))) begin
               starve_cnt_d = starve_cnt_q + 1'b1;
            end
         end
         ACK:     state_d = RUN;
         default: state_d = INIT;
      endcase
   end

   always_comb begin
      bus.rf_ld     = bus.cpu_ld;
      bus.rf_dr     = bus.cpu_dr;
      bus.rf_d      = bus.cpu_d;
      bus.rf_sr1    = bus.cpu_sr1;
      bus.rf_sr2    = bus.cpu_sr2;
      bus.cpu_stall = 1'b0;
      case (state_q)
         INIT: begin
            bus.rf_ld     = 1'b1;
            bus.rf_dr     = init_cnt_q;
            bus.rf_d      = '0;
            bus.cpu_stall = 1'b1;
         end
         RUN: begin
            if (grant) begin
               bus.rf_ld     = bus.dbg_we;
               bus.rf_dr     = bus.dbg_addr;
               bus.rf_d      = bus.dbg_wdata;
               bus.rf_sr1    = bus.dbg_addr;
               bus.cpu_stall = 1'b1;
            end
         end
         default: ;
      endcase
      // Reset overrides everything: no writes land and the CPU is held.
      if (Reset) begin
         bus.rf_ld     = 1'b0;
         bus.cpu_stall = 1'b1;
      end
   end

   assign bus.dbg_ack   = dbg_ack_q & ~Reset;
   assign bus.dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Directed bench for reg_access_ctrl: a per-cycle behavioural model plus literal spot checks.
module tb_reg_access_ctrl;

   logic Clk;
   logic Reset;
   int   checks;
   int   failures;

   reg_access_ctrl_if bus();

   reg_access_ctrl dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Register file the controller drives.
   logic [15:0] rf_mem [8];
   always @(posedge Clk) if (bus.rf_ld) rf_mem[bus.rf_dr] <= bus.rf_d;
   assign bus.rf_sr1_out = rf_mem[bus.rf_sr1];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: mode 1=zeroing, 2=running, 3=ack cycle; m_wait counts passed-over debug cycles.
   int          m_mode;
   int          m_idx;
   int          m_wait;
   logic        m_ack;
   logic [15:0] m_rdata;
   logic [15:0] mregs [8];
   bit          m_valid;
   bit          prev_ack;
   logic        m_g;
   logic [127:0] pk_a, pk_e;

   always @(negedge Clk) begin
      if (Reset) begin
         chk("rst_stall", bus.cpu_stall, 1);
         chk("rst_ack", bus.dbg_ack, 0);
         m_mode  = 1;
         m_idx   = 0;
         m_wait  = 0;
         m_ack   = 1'b0;
         m_rdata = 16'h0000;
         m_valid = 1'b1;
      end else if (m_valid) begin
         chk("ack", bus.dbg_ack, m_ack);
         chk("rdata", bus.dbg_rdata, m_rdata);
         chk("ack_consecutive", prev_ack && bus.dbg_ack, 0);
         if (m_mode == 1) begin
            chk("init_ld", bus.rf_ld, 1);
            chk("init_dr", bus.rf_dr, m_idx);
            chk("init_d", bus.rf_d, 0);
            chk("init_stall", bus.cpu_stall, 1);
            mregs[m_idx] = 16'h0000;
            m_ack = 1'b0;
            m_idx++;
            if (m_idx == 8) m_mode = 2;
         end else begin
            for (int i = 0; i < 8; i++) begin
               pk_a[i*16 +: 16] = rf_mem[i];
               pk_e[i*16 +: 16] = mregs[i];
            end
            chk("regfile", pk_a, pk_e);
            m_g = (m_mode == 2) && bus.dbg_req && (!bus.cpu_ld || m_wait >= 3);
            if (m_g) begin
               chk("gnt_stall", bus.cpu_stall, 1);
               chk("gnt_sr1", bus.rf_sr1, bus.dbg_addr);
               chk("gnt_sr2", bus.rf_sr2, bus.cpu_sr2);
               chk("gnt_ld", bus.rf_ld, bus.dbg_we);
               if (bus.dbg_we) begin
                  chk("gnt_dr", bus.rf_dr, bus.dbg_addr);
                  chk("gnt_d", bus.rf_d, bus.dbg_wdata);
               end
               m_rdata = mregs[bus.dbg_addr];
               if (bus.dbg_we) mregs[bus.dbg_addr] = bus.dbg_wdata;
               m_ack  = 1'b1;
               m_mode = 3;
               m_wait = 0;
            end else begin
               chk("pt_stall", bus.cpu_stall, 0);
               chk("pt_ld", bus.rf_ld, bus.cpu_ld);
               chk("pt_sr1", bus.rf_sr1, bus.cpu_sr1);
               chk("pt_sr2", bus.rf_sr2, bus.cpu_sr2);
               if (bus.cpu_ld) begin
                  chk("pt_dr", bus.rf_dr, bus.cpu_dr);
                  chk("pt_d", bus.rf_d, bus.cpu_d);
                  mregs[bus.cpu_dr] = bus.cpu_d;
               end
               if (m_mode == 2 && bus.dbg_req && bus.cpu_ld && m_wait < 3) m_wait++;
               m_ack  = 1'b0;
               m_mode = 2;
            end
         end
      end
      prev_ack = bus.dbg_ack;
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle();
      bus.cpu_ld = 0; bus.cpu_dr = 0; bus.cpu_d = 0; bus.cpu_sr1 = 3'd1; bus.cpu_sr2 = 3'd2;
      bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = 0; bus.dbg_wdata = 0;
   endtask

   task automatic cpu(input logic ld, input logic [2:0] dr, input logic [15:0] d);
      bus.cpu_ld = ld; bus.cpu_dr = dr; bus.cpu_d = d;
   endtask

   task automatic dbg(input logic req, input logic we, input logic [2:0] a, input logic [15:0] wd);
      bus.dbg_req = req; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = wd;
   endtask

   task automatic run_init();
      for (int i = 0; i < 8; i++) tick();
   endtask

   // {cpu_ld, cpu_dr, cpu_d, dbg_req, dbg_we, dbg_addr, dbg_wdata}
   typedef struct packed {
      logic ld; logic [2:0] dr; logic [15:0] d;
      logic rq; logic we; logic [2:0] a; logic [15:0] wd;
   } vec_t;
   vec_t vecs [9];

   initial begin
      checks = 0; failures = 0; m_valid = 0; prev_ack = 0;
      vecs[0] = '{1, 3'd4, 16'h0A0A, 0, 0, 3'd0, 16'h0000};
      vecs[1] = '{1, 3'd5, 16'h0B0B, 1, 1, 3'd6, 16'hC0DE};
      vecs[2] = '{0, 3'd0, 16'h0000, 1, 1, 3'd6, 16'hC0DE};
      vecs[3] = '{1, 3'd6, 16'h1234, 0, 0, 3'd0, 16'h0000};
      vecs[4] = '{0, 3'd0, 16'h0000, 1, 0, 3'd6, 16'h0000};
      vecs[5] = '{0, 3'd0, 16'h0000, 0, 0, 3'd0, 16'h0000};
      vecs[6] = '{1, 3'd7, 16'hFFFF, 1, 0, 3'd4, 16'h0000};
      vecs[7] = '{1, 3'd7, 16'h8000, 1, 0, 3'd4, 16'h0000};
      vecs[8] = '{0, 3'd0, 16'h0000, 0, 0, 3'd0, 16'h0000};

      Reset = 1; idle();
      tick(); tick();
      Reset = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge Clk);
         chk("lit_init_dr", bus.rf_dr, i);
         chk("lit_init_stall", bus.cpu_stall, 1);
      end
      tick();
      @(negedge Clk); chk("lit_run_stall", bus.cpu_stall, 0);

      // debug write then read back
      tick(); dbg(1, 1, 3'd5, 16'hBEEF);
      @(negedge Clk);
      chk("lit_w_ld", bus.rf_ld, 1); chk("lit_w_dr", bus.rf_dr, 5);
      chk("lit_w_d", bus.rf_d, 16'hBEEF); chk("lit_w_stall", bus.cpu_stall, 1);
      tick(); idle();
      @(negedge Clk); chk("lit_w_ack", bus.dbg_ack, 1);
      tick(); dbg(1, 0, 3'd5, 16'h0000);
      @(negedge Clk); chk("lit_r_ld", bus.rf_ld, 0); chk("lit_r_stall", bus.cpu_stall, 1);
      tick(); idle();
      @(negedge Clk); chk("lit_r_ack", bus.dbg_ack, 1); chk("lit_r_data", bus.dbg_rdata, 16'hBEEF);

      // starvation bound under continuous CPU writes
      tick(); cpu(1, 3'd2, 16'h1111); dbg(1, 0, 3'd2, 16'h0000);
      @(negedge Clk); chk("lit_st1", bus.cpu_stall, 0); chk("lit_st1_ld", bus.rf_ld, 1);
      tick(); cpu(1, 3'd2, 16'h2222);
      @(negedge Clk); chk("lit_st2", bus.cpu_stall, 0);
      tick(); cpu(1, 3'd2, 16'h3333);
      @(negedge Clk); chk("lit_st3", bus.cpu_stall, 0);
      tick(); cpu(1, 3'd2, 16'h4444);
      @(negedge Clk); chk("lit_st4_stall", bus.cpu_stall, 1); chk("lit_st4_ld", bus.rf_ld, 0);
      tick(); dbg(0, 0, 3'd0, 16'h0000); cpu(1, 3'd1, 16'h5555);
      @(negedge Clk); chk("lit_st_ack", bus.dbg_ack, 1); chk("lit_st_data", bus.dbg_rdata, 16'h3333);

      // same-cycle CPU win
      tick(); cpu(1, 3'd3, 16'hA5A5); dbg(1, 0, 3'd0, 16'h0000);
      @(negedge Clk); chk("lit_cw_stall", bus.cpu_stall, 0); chk("lit_cw_dr", bus.rf_dr, 3);
      tick(); idle();
      @(negedge Clk); chk("lit_cw_ack", bus.dbg_ack, 0); chk("lit_cw_r3", rf_mem[3], 16'hA5A5);

      // request held high through ACK
      tick(); dbg(1, 0, 3'd3, 16'h0000);
      @(negedge Clk); chk("lit_h_g1", bus.cpu_stall, 1);
      tick();
      @(negedge Clk); chk("lit_h_a1", bus.dbg_ack, 1); chk("lit_h_a1s", bus.cpu_stall, 0);
      tick();
      @(negedge Clk); chk("lit_h_g2", bus.cpu_stall, 1); chk("lit_h_g2a", bus.dbg_ack, 0);
      tick(); idle();
      @(negedge Clk); chk("lit_h_a2", bus.dbg_ack, 1); chk("lit_h_data", bus.dbg_rdata, 16'hA5A5);

      foreach (vecs[k]) begin
         tick();
         cpu(vecs[k].ld, vecs[k].dr, vecs[k].d);
         dbg(vecs[k].rq, vecs[k].we, vecs[k].a, vecs[k].wd);
      end

      // reset landing on the ack cycle
      tick(); idle(); dbg(1, 1, 3'd1, 16'h9999);
      tick(); idle(); Reset = 1;
      @(negedge Clk); chk("lit_rack_ack", bus.dbg_ack, 0);
      tick(); Reset = 0;
      run_init();

      // reset landing on a write grant
      dbg(1, 1, 3'd5, 16'h7777); Reset = 1;
      @(negedge Clk); chk("lit_rg_stall", bus.cpu_stall, 1); chk("lit_rg_ack", bus.dbg_ack, 0);
      tick(); Reset = 0; idle();
      run_init();
      @(negedge Clk); chk("lit_rg_r5", rf_mem[5], 16'h0000); chk("lit_rg_run", bus.cpu_stall, 0);
      chk("lit_rg_rdata", bus.dbg_rdata, 16'h0000);

      tick(); tick(); tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout reached without finishing");
      $fatal(1, "timeout");
   end

endmodule
